// File: rtl/etx_arbiter.sv
// etx transmit arbiter: merges write, read-request and read-response FIFOs into one registered packet slot.
// Optional `ETX_ARB_ROUNDROBIN_EN replaces the write starvation guard with rd/wr round-robin.
module etx_arbiter #(
    parameter int PW         = 104,
    parameter int STARVE_MAX = 15,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          txwr_fifo_access,
    input  logic [PW-1:0] txwr_fifo_packet,
    output logic          txwr_fifo_wait,
    input  logic          txrd_fifo_access,
    input  logic [PW-1:0] txrd_fifo_packet,
    output logic          txrd_fifo_wait,
    input  logic          txrr_fifo_access,
    input  logic [PW-1:0] txrr_fifo_packet,
    output logic          txrr_fifo_wait,
    input  logic          etx_rd_wait,
    input  logic          etx_wr_wait,
    output logic          etx_access,
    output logic [PW-1:0] etx_packet,
    output logic          etx_rr
);

    logic          etx_access_q, etx_access_d;
    logic [PW-1:0] etx_packet_q, etx_packet_d;
    logic          etx_rr_q, etx_rr_d;
    logic          blocked, ready;
    logic          rr_el, wr_el, rd_el;
    logic          grant_rr, grant_rd, grant_wr;

    // The slot is only stalled by the wait that matches the type of packet it holds.
    assign blocked = etx_access_q & (etx_packet_q[0] ? etx_wr_wait : etx_rd_wait);
    assign ready   = ~blocked;

    assign rr_el = txrr_fifo_access & ~etx_wr_wait;
    assign wr_el = txwr_fifo_access & ~etx_wr_wait;
    assign rd_el = txrd_fifo_access & ~etx_rd_wait;

`ifdef ETX_ARB_ROUNDROBIN_EN
    logic favour_wr_q, favour_wr_d;

    always_comb begin
        grant_rr    = rr_el;
        grant_rd    = ~rr_el & rd_el & (~wr_el | ~favour_wr_q);
        grant_wr    = ~rr_el & wr_el & (~rd_el | favour_wr_q);
        favour_wr_d = favour_wr_q;
        if (ready & grant_rd) favour_wr_d = 1'b1;
        else if (ready & grant_wr) favour_wr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) favour_wr_q <= 1'b0;
        else       favour_wr_q <= favour_wr_d;
    end
`else
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          force_wr;

    assign force_wr = wr_el & (starve_cnt_q == CW'(STARVE_MAX));

    always_comb begin
        grant_wr     = force_wr | (wr_el & ~rr_el & ~rd_el);
        grant_rr     = ~force_wr & rr_el;
        grant_rd     = ~force_wr & ~rr_el & rd_el;
        starve_cnt_d = starve_cnt_q;
        if (~wr_el | (ready & grant_wr))
            starve_cnt_d = '0;
        else if (ready && starve_cnt_q != CW'(STARVE_MAX))
            starve_cnt_d = starve_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`endif

    // Waits are forced high during reset so nothing is popped into a slot that is being cleared.
    assign txrr_fifo_wait = reset | ~(ready & grant_rr);
    assign txrd_fifo_wait = reset | ~(ready & grant_rd);
    assign txwr_fifo_wait = reset | ~(ready & grant_wr);

    always_comb begin
        etx_access_d = etx_access_q;
        etx_packet_d = etx_packet_q;
        etx_rr_d     = etx_rr_q;
        if (ready) begin
            if (grant_rr | grant_rd | grant_wr) begin
                etx_access_d = 1'b1;
                etx_rr_d     = grant_rr;
                etx_packet_d = grant_rr ? txrr_fifo_packet :
                               grant_rd ? txrd_fifo_packet : txwr_fifo_packet;
            end else begin
                etx_access_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            etx_access_q <= 1'b0;
            etx_packet_q <= '0;
            etx_rr_q     <= 1'b0;
        end else begin
            etx_access_q <= etx_access_d;
            etx_packet_q <= etx_packet_d;
            etx_rr_q     <= etx_rr_d;
        end
    end

    assign etx_access = etx_access_q;
    assign etx_packet = etx_packet_q;
    assign etx_rr     = etx_rr_q;

endmodule

// File: tb/tb_etx_arbiter.sv
// Directed bench for etx_arbiter: reset, priority/starvation (or round-robin), remote waits, throughput.
module tb_etx_arbiter;
    localparam int PW = 104;
    localparam logic [PW-1:0] PK_RR = 104'hCAFE_0003;
    localparam logic [PW-1:0] PK_RD = 104'hBEEF_0002;
    localparam logic [PW-1:0] PK_WR = 104'hD00D_0001;
    localparam logic [PW-1:0] PK_A1 = 104'h1234_00A1;
    localparam logic [PW-1:0] PK_A3 = 104'h1234_00A3;

    logic          clk = 1'b0;
    logic          reset;
    logic          txwr_fifo_access, txrd_fifo_access, txrr_fifo_access;
    logic [PW-1:0] txwr_fifo_packet, txrd_fifo_packet, txrr_fifo_packet;
    logic          txwr_fifo_wait, txrd_fifo_wait, txrr_fifo_wait;
    logic          etx_rd_wait, etx_wr_wait;
    logic          etx_access, etx_rr;
    logic [PW-1:0] etx_packet;

    int pass_cnt = 0;
    int total_cnt = 0;

    etx_arbiter dut (
        .clk(clk), .reset(reset),
        .txwr_fifo_access(txwr_fifo_access), .txwr_fifo_packet(txwr_fifo_packet), .txwr_fifo_wait(txwr_fifo_wait),
        .txrd_fifo_access(txrd_fifo_access), .txrd_fifo_packet(txrd_fifo_packet), .txrd_fifo_wait(txrd_fifo_wait),
        .txrr_fifo_access(txrr_fifo_access), .txrr_fifo_packet(txrr_fifo_packet), .txrr_fifo_wait(txrr_fifo_wait),
        .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait),
        .etx_access(etx_access), .etx_packet(etx_packet), .etx_rr(etx_rr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        txwr_fifo_access = 1'b0; txrd_fifo_access = 1'b0; txrr_fifo_access = 1'b0;
        txwr_fifo_packet = PK_WR; txrd_fifo_packet = PK_RD; txrr_fifo_packet = PK_RR;
        etx_rd_wait = 1'b0; etx_wr_wait = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        txwr_fifo_access = 1'b1; txrd_fifo_access = 1'b1; txrr_fifo_access = 1'b1;
        tick();
        #1;
        total_cnt++;
        if ({txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait} !== 3'b111)
            $display("FAIL reset_waits: got %b want 111", {txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait});
        else pass_cnt++;
        total_cnt++;
        if (etx_access !== 1'b0) $display("FAIL reset_access: got %b want 0", etx_access);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait} !== 3'b011)
            $display("FAIL first_pop_rr: got %b want 011", {txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({etx_access, etx_rr, etx_packet} !== {1'b1, 1'b1, PK_RR})
            $display("FAIL first_out_rr: got acc=%b rr=%b pkt=%h want 1 1 %h", etx_access, etx_rr, etx_packet, PK_RR);
        else pass_cnt++;
    endtask

    task automatic test_starve();
        logic [PW-1:0] exp_pkt;
        do_reset();
        txrd_fifo_access = 1'b1; txwr_fifo_access = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            total_cnt++;
            if ({txrd_fifo_wait, txwr_fifo_wait} !== ((i % 16 == 15) ? 2'b10 : 2'b01))
                $display("FAIL starve_grant[%0d]: got rd_wait/wr_wait=%b want %b", i,
                         {txrd_fifo_wait, txwr_fifo_wait}, (i % 16 == 15) ? 2'b10 : 2'b01);
            else pass_cnt++;
            if (i > 0) begin
                exp_pkt = ((i - 1) % 16 == 15) ? PK_WR : PK_RD;
                total_cnt++;
                if (etx_packet !== exp_pkt)
                    $display("FAIL starve_out[%0d]: got %h want %h", i, etx_packet, exp_pkt);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_roundrobin();
        logic [2:0] tbl [8];
        tbl = '{3'b101, 3'b110, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110, 3'b101};
        do_reset();
        txrd_fifo_access = 1'b1; txwr_fifo_access = 1'b1;
        for (int i = 0; i < 8; i++) begin
            txrr_fifo_access = (i == 4);
            #1;
            total_cnt++;
            if ({txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait} !== tbl[i])
                $display("FAIL rr_grant[%0d]: got %b want %b", i,
                         {txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait}, tbl[i]);
            else pass_cnt++;
            tick();
        end
        txrr_fifo_access = 1'b0;
    endtask

    task automatic test_wr_wait();
        do_reset();
        txwr_fifo_access = 1'b1; etx_wr_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if ({txwr_fifo_wait, etx_access} !== 2'b10)
                $display("FAIL wrwait_hold[%0d]: got wait/access=%b want 10", i, {txwr_fifo_wait, etx_access});
            else pass_cnt++;
            tick();
        end
        etx_wr_wait = 1'b0;
        #1;
        total_cnt++;
        if (txwr_fifo_wait !== 1'b0) $display("FAIL wrwait_release_pop: got %b want 0", txwr_fifo_wait);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({etx_access, etx_rr, etx_packet} !== {1'b1, 1'b0, PK_WR})
            $display("FAIL wrwait_out: got acc=%b rr=%b pkt=%h want 1 0 %h", etx_access, etx_rr, etx_packet, PK_WR);
        else pass_cnt++;
    endtask

    task automatic test_rd_wait();
        do_reset();
        txwr_fifo_access = 1'b1;
        tick();
        etx_rd_wait = 1'b1; txrd_fifo_access = 1'b1;
        #1;
        total_cnt++;
        if ({txrd_fifo_wait, txwr_fifo_wait} !== 2'b10)
            $display("FAIL rdwait_wr_flows: got rd/wr wait=%b want 10", {txrd_fifo_wait, txwr_fifo_wait});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({etx_access, etx_packet} !== {1'b1, PK_WR})
            $display("FAIL rdwait_wr_out: got acc=%b pkt=%h want 1 %h", etx_access, etx_packet, PK_WR);
        else pass_cnt++;
        txrr_fifo_access = 1'b1;
        #1;
        total_cnt++;
        if ({txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait} !== 3'b011)
            $display("FAIL rdwait_rr_pop: got %b want 011", {txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({etx_rr, etx_packet} !== {1'b1, PK_RR})
            $display("FAIL rdwait_rr_out: got rr=%b pkt=%h want 1 %h", etx_rr, etx_packet, PK_RR);
        else pass_cnt++;
        txrr_fifo_access = 1'b0; txwr_fifo_access = 1'b0;
        #1;
        total_cnt++;
        if (txrd_fifo_wait !== 1'b1) $display("FAIL rdwait_no_rd_pop: got %b want 1", txrd_fifo_wait);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (etx_access !== 1'b0) $display("FAIL rdwait_drain: got %b want 0", etx_access);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        do_reset();
        txwr_fifo_access = 1'b1; txwr_fifo_packet = PK_A1;
        tick();
        etx_wr_wait = 1'b1; txwr_fifo_packet = PK_A3;
        txrd_fifo_access = 1'b1; txrr_fifo_access = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++;
            if ({txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait, etx_access, etx_packet} !== {4'b1111, PK_A1})
                $display("FAIL hold[%0d]: got waits=%b acc=%b pkt=%h want 111 1 %h", i,
                         {txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait}, etx_access, etx_packet, PK_A1);
            else pass_cnt++;
            tick();
        end
        etx_wr_wait = 1'b0; txrd_fifo_access = 1'b0; txrr_fifo_access = 1'b0;
        #1;
        total_cnt++;
        if (txwr_fifo_wait !== 1'b0) $display("FAIL hold_release_pop: got %b want 0", txwr_fifo_wait);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({etx_access, etx_packet} !== {1'b1, PK_A3})
            $display("FAIL hold_next: got acc=%b pkt=%h want 1 %h", etx_access, etx_packet, PK_A3);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_pkt;
        do_reset();
        txrr_fifo_access = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_pkt = PK_RR + PW'(i * 16);
            txrr_fifo_packet = exp_pkt;
            tick();
            total_cnt++;
            if ({etx_access, etx_rr, etx_packet} !== {1'b1, 1'b1, exp_pkt})
                $display("FAIL b2b[%0d]: got acc=%b rr=%b pkt=%h want 1 1 %h", i, etx_access, etx_rr, etx_packet, exp_pkt);
            else pass_cnt++;
        end
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait} !== 3'b111)
            $display("FAIL midreset_waits: got %b want 111", {txrr_fifo_wait, txrd_fifo_wait, txwr_fifo_wait});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({etx_access, etx_rr, etx_packet} !== {1'b0, 1'b0, {PW{1'b0}}})
            $display("FAIL midreset_slot: got acc=%b rr=%b pkt=%h want 0 0 0", etx_access, etx_rr, etx_packet);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef ETX_ARB_ROUNDROBIN_EN
        test_roundrobin();
`else
        test_starve();
`endif
        test_wr_wait();
        test_rd_wait();
        test_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
